neuron_stream: RTL and testbench
================================

NEURON_STREAM -- requirements
Module: neuron_stream

Interface
REQ-001 SHALL have parameter INPUT_SIZE, default 784, number of input/weight pairs per dot product.
REQ-002 SHALL have parameter LANES, default 4, pairs consumed per input beat; INPUT_SIZE % LANES == 0, else elaboration error.
REQ-003 SHALL have parameter DATA_W, default 16, signed width of inputs, weights, bias and result.
REQ-004 SHALL have parameter FRAC_BITS, default 8, arithmetic right shift applied to the accumulator.
REQ-005 SHALL have parameter ACT_MODE, default 1, where 0 = identity and 1 = ReLU.
REQ-006 SHALL derive localparam ACC_W = 2*DATA_W + $clog2(INPUT_SIZE) and BEATS = INPUT_SIZE/LANES.
REQ-007 SHALL use one clock; reset is synchronous and active-high; ports named clk and rst.
REQ-008 clk  input  1  rising-edge clock.
REQ-009 rst  input  1  synchronous active-high reset.
REQ-010 start  input  1  request new dot product; accepted only in IDLE.
REQ-011 bias  input  DATA_W signed  captured on the cycle start is accepted.
REQ-012 in_valid  input  1  input beat valid.
REQ-013 in_ready  output  1  high only in ACCUM.
REQ-014 in_data  input  LANES x DATA_W signed  input lanes, lane 0 = lowest element index.
REQ-015 in_weight  input  LANES x DATA_W signed  weight lanes, aligned with in_data.
REQ-016 out_valid  output  1  result valid; held until accepted.
REQ-017 out_ready  input  1  downstream accepts result.
REQ-018 out_data  output  DATA_W signed  activated, saturated result.
REQ-019 busy  output  1  high in any state except IDLE.

Function
REQ-020 SHALL implement states IDLE, ACCUM, FINISH and OUT.
REQ-021 IDLE -> ACCUM on start; SHALL clear the accumulator and beat counter and latch bias.
REQ-022 In ACCUM, each cycle with in_valid && in_ready SHALL add the sum of LANES products (sign-extended to ACC_W) to the accumulator and increment the beat counter.
REQ-023 In ACCUM, cycles with in_valid low SHALL leave the accumulator and counter unchanged; gaps of any length are legal.
REQ-024 Acceptance of beat BEATS-1 SHALL move the FSM to FINISH; no further beats SHALL be accepted.
REQ-025 FINISH (one cycle) SHALL compute t = (acc >>> FRAC_BITS) + sign-extended bias at ACC_W+1 bits, with truncation toward negative infinity.
REQ-026 Activation in FINISH: ACT_MODE=1 with t <= 0 gives 0; otherwise t SHALL saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-027 FINISH SHALL register out_data, assert out_valid and go to OUT; out_valid SHALL rise 2 cycles after the last beat handshake cycle.
REQ-028 In OUT, out_data and out_valid SHALL hold stable until out_valid && out_ready, then deassert out_valid and return to IDLE in the next cycle.
REQ-029 start outside IDLE, including a start in the same cycle as the output handshake, SHALL be ignored.
REQ-030 in_valid outside ACCUM SHALL be ignored; in_ready SHALL be 0 there.
REQ-031 The beat counter SHALL be $clog2(BEATS+1) bits and SHALL never wrap.

Reset
REQ-032 With rst high at a clock edge, the block SHALL enter IDLE with out_valid=0, out_data=0, in_ready=0, busy=0, accumulator=0, counter=0 and latched bias=0.
REQ-033 Reset mid-operation SHALL discard partial results; no out_valid SHALL follow for the aborted operation.

Structure
REQ-034 Package neuron_pkg SHALL hold the state enum type and the ACT_IDENTITY/ACT_RELU constants.
REQ-035 The combinational LANES-wide multiply-and-sum tree SHALL be sub-module dot_lanes, parameterised by LANES, DATA_W and output width.

Verification (INPUT_SIZE=8, LANES=4, DATA_W=16, FRAC_BITS=8)
REQ-036 All inputs 256, weights 256, bias 0, ACT_MODE=1, two back-to-back beats -> out_data=2048 with out_valid 2 cycles after the second beat.
REQ-037 Inputs 256, weights -256, bias 10: ACT_MODE=1 -> 0; ACT_MODE=0 -> -2038.
REQ-038 Inputs 32767, weights 32767 -> 32767; ACT_MODE=0 with weights -32768 -> -32768.
REQ-039 Random in_valid gaps, out_ready held low 5 cycles, start pulsed in OUT -> out_data stable, start ignored, result equals the golden model.
REQ-040 rst asserted after beat 1 of 2 -> IDLE with out_valid=0; a new operation then gives the correct result.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared types and constants for the streaming dot-product neuron.
package neuron_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_FINISH,
    ST_OUT
  } state_t;

  localparam int ACT_IDENTITY = 0;
  localparam int ACT_RELU     = 1;

endpackage

// File: rtl/dot_lanes.sv
// Combinational LANES-wide signed multiply and sum, sign-extended to OUT_W.
module dot_lanes #(
  parameter int LANES  = 4,
  parameter int DATA_W = 16,
  parameter int OUT_W  = 35
) (
  input  logic [LANES*DATA_W-1:0] in_data,
  input  logic [LANES*DATA_W-1:0] in_weight,
  output logic signed [OUT_W-1:0] sum
);

  logic signed [DATA_W-1:0]   a;
  logic signed [DATA_W-1:0]   b;
  logic signed [2*DATA_W-1:0] prod;

  always_comb begin
    sum  = '0;
    a    = '0;
    b    = '0;
    prod = '0;
    for (int i = 0; i < LANES; i++) begin
      a    = in_data[i*DATA_W +: DATA_W];
      b    = in_weight[i*DATA_W +: DATA_W];
      prod = a * b;
      sum  = sum + OUT_W'(prod);
    end
  end

endmodule

// File: rtl/neuron_stream.sv
// Streaming neuron: accumulates LANES products per beat, then shift, bias,
// activation and saturation into a held output register.
//
//   state     | meaning
//   ST_IDLE   | waiting for start; bias captured on accept
//   ST_ACCUM  | accepting input beats until BEATS have arrived
//   ST_FINISH | one cycle: scale, add bias, activate, saturate
//   ST_OUT    | result held until out_ready
module neuron_stream
  import neuron_pkg::*;
#(
  parameter int INPUT_SIZE = 784,
  parameter int LANES      = 4,
  parameter int DATA_W     = 16,
  parameter int FRAC_BITS  = 8,
  parameter int ACT_MODE   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic signed [DATA_W-1:0]   bias,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*DATA_W-1:0]    in_data,
  input  logic [LANES*DATA_W-1:0]    in_weight,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [DATA_W-1:0]   out_data,
  output logic                       busy
);

  localparam int ACC_W = 2*DATA_W + $clog2(INPUT_SIZE);
  localparam int BEATS = INPUT_SIZE / LANES;
  localparam int CNT_W = $clog2(BEATS+1);
  localparam logic signed [ACC_W:0] SAT_MAX =
    {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

  if (INPUT_SIZE % LANES != 0) begin : g_size_check
    $error("neuron_stream: INPUT_SIZE must be a multiple of LANES");
  end

  state_t                    state_q, state_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic signed [DATA_W-1:0]  bias_q, bias_d;
  logic signed [DATA_W-1:0]  out_data_q, out_data_d;
  logic                      out_valid_q, out_valid_d;

  logic signed [ACC_W-1:0]   beat_sum;
  logic signed [ACC_W:0]     t;
  logic signed [DATA_W-1:0]  act_val;

  dot_lanes #(
    .LANES  (LANES),
    .DATA_W (DATA_W),
    .OUT_W  (ACC_W)
  ) u_dot (
    .in_data   (in_data),
    .in_weight (in_weight),
    .sum       (beat_sum)
  );

  // Arithmetic shift floors toward negative infinity.
  always_comb begin
    t = (ACC_W+1)'(acc_q >>> FRAC_BITS) + (ACC_W+1)'(bias_q);
    if (ACT_MODE == ACT_RELU && (t[ACC_W] || t == '0)) act_val = '0;
    else if (t > SAT_MAX)                               act_val = SAT_MAX[DATA_W-1:0];
    else if (t < SAT_MIN)                               act_val = SAT_MIN[DATA_W-1:0];
    else                                                act_val = t[DATA_W-1:0];
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    bias_d      = bias_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ACCUM;
          acc_d   = '0;
          cnt_d   = '0;
          bias_d  = bias;
        end
      end
      ST_ACCUM: begin
        if (in_valid) begin
          acc_d = acc_q + beat_sum;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(BEATS-1)) state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        out_data_d  = act_val;
        out_valid_d = 1'b1;
        state_d     = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      bias_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      bias_q      <= bias_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == ST_ACCUM);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_neuron_stream.sv
// Directed bench: ReLU and identity instances share stimulus; a scoreboard
// holds golden results pushed at start and popped when out_valid rises.
module tb_neuron_stream;

  localparam int N  = 8;
  localparam int L  = 4;
  localparam int DW = 16;
  localparam int NB = N / L;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic signed [DW-1:0] bias = '0;
  logic                 in_valid = 1'b0;
  logic [L*DW-1:0]      in_data = '0;
  logic [L*DW-1:0]      in_weight = '0;
  logic                 out_ready = 1'b0;

  logic                 in_ready_r, out_valid_r, busy_r;
  logic signed [DW-1:0] out_data_r;
  logic                 in_ready_l, out_valid_l, busy_l;
  logic signed [DW-1:0] out_data_l;

  int checks = 0;
  int errors = 0;

  logic signed [DW-1:0] vx [N];
  logic signed [DW-1:0] vw [N];
  longint exp_relu [$];
  longint exp_lin  [$];

  always #5 clk = ~clk;

  neuron_stream #(.INPUT_SIZE(N), .LANES(L), .DATA_W(DW), .FRAC_BITS(8), .ACT_MODE(1)) u_relu (
    .clk(clk), .rst(rst), .start(start), .bias(bias), .in_valid(in_valid),
    .in_ready(in_ready_r), .in_data(in_data), .in_weight(in_weight),
    .out_valid(out_valid_r), .out_ready(out_ready), .out_data(out_data_r), .busy(busy_r));

  neuron_stream #(.INPUT_SIZE(N), .LANES(L), .DATA_W(DW), .FRAC_BITS(8), .ACT_MODE(0)) u_lin (
    .clk(clk), .rst(rst), .start(start), .bias(bias), .in_valid(in_valid),
    .in_ready(in_ready_l), .in_data(in_data), .in_weight(in_weight),
    .out_valid(out_valid_l), .out_ready(out_ready), .out_data(out_data_l), .busy(busy_l));

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  function automatic longint model(input bit relu, input longint b);
    longint acc, t;
    acc = 0;
    for (int i = 0; i < N; i++) acc += longint'(vx[i]) * longint'(vw[i]);
    t = (acc >>> 8) + b;
    if (relu && t <= 0) return 0;
    if (t > 32767) return 32767;
    if (t < -32768) return -32768;
    return t;
  endfunction

  task automatic fill(input int x, input int w);
    for (int i = 0; i < N; i++) begin
      vx[i] = DW'(x);
      vw[i] = DW'(w);
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < N; i++) begin
      vx[i] = DW'(int'($urandom_range(0, 600)) - 300);
      vw[i] = DW'(int'($urandom_range(0, 600)) - 300);
    end
  endtask

  task automatic drive_beat(input int beat);
    for (int l = 0; l < L; l++) begin
      in_data[l*DW +: DW]   = vx[beat*L + l];
      in_weight[l*DW +: DW] = vw[beat*L + l];
    end
  endtask

  task automatic do_start(input int b);
    bias = DW'(b);
    exp_relu.push_back(model(1'b1, longint'(b)));
    exp_lin.push_back(model(1'b0, longint'(b)));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bias  = DW'($urandom);
  endtask

  task automatic send_beats(input int gap_max);
    for (int beat = 0; beat < NB; beat++) begin
      repeat ($urandom_range(0, gap_max)) begin
        in_valid  = 1'b0;
        in_data   = {$urandom, $urandom};
        in_weight = {$urandom, $urandom};
        @(negedge clk);
      end
      chk("in_ready_accum", 64'(in_ready_r), 1);
      drive_beat(beat);
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("in_ready_finish", 64'(in_ready_r), 0);
    chk("valid_low_finish", 64'(out_valid_r), 0);
    @(negedge clk);
  endtask

  task automatic collect(input string tag, input int hold, input bit pulse);
    longint er, el;
    logic signed [DW-1:0] first_r, first_l;
    er = 0;
    el = 0;
    if (exp_relu.size() == 0 || exp_lin.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_scoreboard observed=empty expected=entry", tag);
    end else begin
      er = exp_relu.pop_front();
      el = exp_lin.pop_front();
    end
    chk({tag, "_valid_rise"}, 64'(out_valid_r), 1);
    chk({tag, "_relu"}, $signed(out_data_r), er);
    chk({tag, "_lin"}, $signed(out_data_l), el);
    first_r = out_data_r;
    first_l = out_data_l;
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      start     = pulse && (h == hold / 2);
      in_valid  = 1'b1;
      in_data   = {$urandom, $urandom};
      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'b0;
      chk({tag, "_hold_valid"}, 64'(out_valid_r), 1);
      chk({tag, "_hold_relu"}, $signed(out_data_r), $signed(first_r));
      chk({tag, "_hold_lin"}, $signed(out_data_l), $signed(first_l));
      chk({tag, "_hold_inrdy"}, 64'(in_ready_r), 0);
    end
    out_ready = 1'b1;
    start     = pulse;
    @(negedge clk);
    out_ready = 1'b0;
    start     = 1'b0;
    chk({tag, "_valid_drop"}, 64'(out_valid_r), 0);
    chk({tag, "_idle_after"}, 64'(busy_r), 0);
  endtask

  initial begin
    bit saw_valid;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_valid", 64'(out_valid_r), 0);
    chk("rst_data", $signed(out_data_r), 0);
    chk("rst_inrdy", 64'(in_ready_r), 0);
    chk("rst_busy", 64'(busy_r), 0);
    chk("rst_busy_lin", 64'(busy_l), 0);

    // in_valid while idle must be ignored
    in_valid = 1'b1;
    in_data  = {4{16'sd100}};
    in_weight = {4{16'sd100}};
    @(negedge clk);
    in_valid = 1'b0;
    chk("idle_inrdy", 64'(in_ready_l), 0);

    fill(256, 256);
    do_start(0);
    chk("busy_accum", 64'(busy_r), 1);
    send_beats(0);
    collect("pos", 0, 1'b0);

    fill(256, -256);
    do_start(10);
    send_beats(0);
    collect("neg", 1, 1'b0);

    fill(32767, 32767);
    do_start(0);
    send_beats(1);
    collect("satp", 0, 1'b0);

    fill(32767, -32768);
    do_start(0);
    send_beats(1);
    collect("satn", 0, 1'b0);

    // floor: acc = -8 shifts to -1, not 0
    fill(1, -1);
    do_start(0);
    send_beats(0);
    collect("floor", 0, 1'b0);

    for (int k = 0; k < 3; k++) begin
      fill_rand();
      do_start(int'($urandom_range(0, 200)) - 100);
      send_beats(4);
      collect("rand", 5, 1'b1);
    end

    // reset after the first of two beats
    fill(300, 300);
    do_start(7);
    drive_beat(0);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(exp_relu.pop_back());
    void'(exp_lin.pop_back());
    chk("abort_busy", 64'(busy_r), 0);
    chk("abort_valid", 64'(out_valid_r), 0);
    chk("abort_inrdy", 64'(in_ready_r), 0);
    chk("abort_data", $signed(out_data_r), 0);
    saw_valid = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid_r || out_valid_l) saw_valid = 1'b1;
    end
    chk("abort_no_valid", 64'(saw_valid), 0);

    fill_rand();
    do_start(25);
    send_beats(2);
    collect("post_rst", 2, 1'b0);

    chk("scoreboard_empty", 64'(exp_relu.size() + exp_lin.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
